// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for an external 8-bit combinational ALU: register file, valid/ready
// command and response channels, 16-bit chaining on register pairs, sticky flags.
module alu_cmd_sequencer #(
   parameter  int NREGS = 4,
   localparam int RW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [7:0]    cmd_op,
   input  logic [RW-1:0] cmd_dst,
   input  logic [RW-1:0] cmd_sa,
   input  logic [RW-1:0] cmd_sb,
   input  logic          cmd_imm_en,
   input  logic [7:0]    cmd_imm,
   input  logic          cmd_wide,
   input  logic          cmd_load,
   output logic [7:0]    alu_a,
   output logic [7:0]    alu_b,
   output logic [7:0]    alu_op,
   input  logic [7:0]    alu_z,
   input  logic [7:0]    alu_flags,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [15:0]   rsp_data,
   output logic [7:0]    rsp_flags,
   output logic [7:0]    flags_q,
   input  logic          flags_clr,
   input  logic [RW-1:0] rd_idx,
   output logic [7:0]    rd_data
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LO   = 3'd1,
      ST_HI   = 3'd2,
      ST_INC  = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   state_t        state_r, state_n_s;
   logic [7:0]    regs_r [NREGS];
   logic [RW-1:0] dst_r;
   logic          wide_r, add_r, carry_r, hi_ovf_r;
   logic [7:0]    a_hi_r, b_hi_r, z_lo_r, flags_lo_r;

   logic [RW-1:0] dst_s, sa_s, sb_s, sa_hi_s, sb_hi_s, dst_hi_s;
   logic [7:0]    b_lo_s, b_hi_s;
   logic          wide_legal_s, start_s;
   logic          rsp_set_s, wr_lo_en_s, wr_hi_en_s;
   logic [RW-1:0] wr_lo_idx_s;
   logic [7:0]    wr_lo_data_s, wr_hi_data_s;
   logic [15:0]   rsp_data_s;
   logic [7:0]    rsp_flags_s;

   // Wide commands address an aligned pair, so the index LSB is dropped.
   assign dst_s        = cmd_wide ? {cmd_dst[RW-1:1], 1'b0} : cmd_dst;
   assign sa_s         = cmd_wide ? {cmd_sa[RW-1:1], 1'b0} : cmd_sa;
   assign sb_s         = cmd_wide ? {cmd_sb[RW-1:1], 1'b0} : cmd_sb;
   assign sa_hi_s      = {cmd_sa[RW-1:1], 1'b1};
   assign sb_hi_s      = {cmd_sb[RW-1:1], 1'b1};
   assign dst_hi_s     = {dst_r[RW-1:1], 1'b1};
   assign b_lo_s       = cmd_imm_en ? cmd_imm : regs_r[sb_s];
   assign b_hi_s       = cmd_imm_en ? 8'h00 : regs_r[sb_hi_s];
   assign wide_legal_s = (cmd_op[4:0] == 5'd0) ||
                         ((cmd_op[4:0] >= 5'd5) && (cmd_op[4:0] <= 5'd11));
   assign start_s      = (state_r == ST_IDLE) && (state_n_s == ST_LO);
   assign rd_data      = regs_r[rd_idx];

   // Next state, response contents and register write-back selection.
   always_comb begin
      state_n_s    = state_r;
      rsp_set_s    = 1'b0;
      rsp_data_s   = 16'h0000;
      rsp_flags_s  = 8'h00;
      wr_lo_en_s   = 1'b0;
      wr_hi_en_s   = 1'b0;
      wr_lo_idx_s  = dst_r;
      wr_lo_data_s = z_lo_r;
      wr_hi_data_s = alu_z;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_load) begin
                  state_n_s    = ST_RESP;
                  rsp_set_s    = 1'b1;
                  rsp_data_s   = {8'h00, cmd_imm};
                  wr_lo_en_s   = 1'b1;
                  wr_lo_idx_s  = cmd_dst;
                  wr_lo_data_s = cmd_imm;
               end else if (cmd_wide && !wide_legal_s) begin
                  state_n_s   = ST_RESP;
                  rsp_set_s   = 1'b1;
                  rsp_flags_s = 8'h20;
               end else begin
                  state_n_s = ST_LO;
               end
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_LO: begin
            if (wide_r) begin
               state_n_s = ST_HI;
            end else begin
               state_n_s    = ST_RESP;
               rsp_set_s    = 1'b1;
               rsp_data_s   = {8'h00, alu_z};
               rsp_flags_s  = alu_flags;
               wr_lo_en_s   = 1'b1;
               wr_lo_data_s = alu_z;
            end
         end
         ST_HI: begin
            if (add_r && carry_r) begin
               state_n_s = ST_INC;
            end else begin
               state_n_s   = ST_RESP;
               rsp_set_s   = 1'b1;
               rsp_data_s  = {alu_z, z_lo_r};
               rsp_flags_s = add_r ? {7'h00, alu_flags[0]} : (flags_lo_r | alu_flags);
               wr_lo_en_s  = 1'b1;
               wr_hi_en_s  = 1'b1;
            end
         end
         ST_INC: begin
            state_n_s   = ST_RESP;
            rsp_set_s   = 1'b1;
            rsp_data_s  = {alu_z, z_lo_r};
            rsp_flags_s = {7'h00, hi_ovf_r | alu_flags[0]};
            wr_lo_en_s  = 1'b1;
            wr_hi_en_s  = 1'b1;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_n_s = ST_IDLE;
            end else begin
               state_n_s = ST_RESP;
            end
         end
         default: state_n_s = ST_IDLE;
      endcase
   end

   // State register and handshake outputs, registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
      end else begin
         state_r   <= state_n_s;
         cmd_ready <= (state_n_s == ST_IDLE);
         rsp_valid <= (state_n_s == ST_RESP);
      end
   end

   // Register file write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_r[i] <= 8'h00;
      end else begin
         if (wr_lo_en_s) regs_r[wr_lo_idx_s] <= wr_lo_data_s;
         if (wr_hi_en_s) regs_r[dst_hi_s]    <= wr_hi_data_s;
      end
   end

   // ALU operand drive and per-command context for the chained steps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= 8'h00;
         alu_b      <= 8'h00;
         alu_op     <= 8'h00;
         a_hi_r     <= 8'h00;
         b_hi_r     <= 8'h00;
         z_lo_r     <= 8'h00;
         flags_lo_r <= 8'h00;
         dst_r      <= '0;
         wide_r     <= 1'b0;
         add_r      <= 1'b0;
         carry_r    <= 1'b0;
         hi_ovf_r   <= 1'b0;
      end else if (start_s) begin
         alu_a  <= regs_r[sa_s];
         alu_b  <= b_lo_s;
         alu_op <= cmd_wide ? {3'b000, cmd_op[4:0]} : cmd_op;
         a_hi_r <= regs_r[sa_hi_s];
         b_hi_r <= b_hi_s;
         dst_r  <= dst_s;
         wide_r <= cmd_wide;
         add_r  <= cmd_wide && (cmd_op[4:0] == 5'd0);
      end else if ((state_r == ST_LO) && wide_r) begin
         z_lo_r     <= alu_z;
         carry_r    <= alu_flags[0];
         flags_lo_r <= alu_flags;
         alu_a      <= a_hi_r;
         alu_b      <= b_hi_r;
      end else if ((state_r == ST_HI) && (state_n_s == ST_INC)) begin
         hi_ovf_r <= alu_flags[0];
         alu_a    <= alu_z;
         alu_b    <= 8'h01;
         alu_op   <= 8'h00;
      end
   end

   // Response registers and sticky flags; a clear coinciding with new flags keeps the new ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data  <= 16'h0000;
         rsp_flags <= 8'h00;
         flags_q   <= 8'h00;
      end else if (rsp_set_s) begin
         rsp_data  <= rsp_data_s;
         rsp_flags <= rsp_flags_s;
         flags_q   <= (flags_clr ? 8'h00 : flags_q) | rsp_flags_s;
      end else if (flags_clr) begin
         flags_q <= 8'h00;
      end
   end

endmodule
